lfsr_prbs_checker: RTL and testbench



---
 rtl/lfsr_pkg.sv | 27 ++
 rtl/lfsr_prbs_checker.sv | 114 +++++++++++
 tb/tb_lfsr_prbs_checker.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the PRNG and its PRBS checker.
// x^16+x^14+x^13+x^11+1 in Fibonacci form, shifting right.
package lfsr_pkg;

    localparam int LFSR_W = 16;

    // Feedback taps: bits 0, 2, 3 and 5 of the current word.
    localparam int TAP_A = 0;
    localparam int TAP_B = 2;
    localparam int TAP_C = 3;
    localparam int TAP_D = 5;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] r
    );
        logic fb;
        fb = r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D];
        return {fb, r[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker for the lfsr_prng word stream.
// Seeds from received data, locks after a run of matches, counts errors.
module lfsr_prbs_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    import lfsr_pkg::*;

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);

    state_t            state;
    logic [LFSR_W-1:0] expected;
    logic [MW-1:0]     match_cnt;
    logic [LW-1:0]     miss_cnt;

    logic is_match;
    logic is_zero;
    logic lock_hit;
    logic loss_hit;
    logic count_err;

    assign is_match = (in_data == expected);
    assign is_zero  = (in_data == '0);

    // The match/miss that would complete the run this word.
    assign lock_hit = (32'(match_cnt) + 32'd1) == 32'(LOCK_COUNT);
    assign loss_hit = (32'(miss_cnt) + 32'd1) == 32'(LOSS_COUNT);

    assign count_err = in_valid && (state == LOCKED) && !is_match;

    // Acquisition / flywheel FSM with registered lock and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            expected  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                unique case (state)
                    HUNT: begin
                        // Zero is the lock-up value and cannot seed.
                        if (!is_zero) begin
                            expected  <= lfsr_next(in_data);
                            match_cnt <= '0;
                            state     <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (is_match) begin
                            expected  <= lfsr_next(in_data);
                            match_cnt <= match_cnt + 1'b1;
                            if (lock_hit) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else if (!is_zero) begin
                            expected  <= lfsr_next(in_data);
                            match_cnt <= '0;
                        end else begin
                            state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        // Predict from our own sequence, never from data.
                        expected <= lfsr_next(expected);
                        if (is_match) begin
                            miss_cnt <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            miss_cnt  <= miss_cnt + 1'b1;
                            if (loss_hit) begin
                                state  <= HUNT;
                                locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating error counter; a clear coinciding with an error leaves 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= count_err ? ERR_W'(1) : '0;
        end else if (count_err && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Scenario bench for lfsr_prbs_checker: lock, errors, loss, clear,
// saturation and reset, against an arithmetic PRBS reference.
module tb_lfsr_prbs_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        err_clr = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    logic        rst2 = 1'b0;
    logic        in_valid2 = 1'b0;
    logic [15:0] in_data2 = '0;
    logic        err_clr2 = 1'b0;
    logic        locked2;
    logic        err_pulse2;
    logic [3:0]  err_count2;

    int tests = 0;
    int fails = 0;

    logic [15:0] gen;
    logic [15:0] gen2;
    int          ecnt;

    always #5 clk = ~clk;

    lfsr_prbs_checker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    lfsr_prbs_checker #(.ERR_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst2),
        .in_valid  (in_valid2),
        .in_data   (in_data2),
        .err_clr   (err_clr2),
        .locked    (locked2),
        .err_pulse (err_pulse2),
        .err_count (err_count2)
    );

    // Reference step: shift right, feedback = parity of taps 0,2,3,5.
    function automatic logic [15:0] nxt(input logic [15:0] r);
        int fb;
        fb = $countones(r & 16'h002D) % 2;
        return (r >> 1) + (fb != 0 ? 16'h8000 : 16'h0000);
    endfunction

    function automatic logic [15:0] rand_mask();
        return 16'($urandom_range(1, 16'hFFFF));
    endfunction

    task automatic step(input logic v, input logic [15:0] d,
                        input logic clr);
        in_valid = v;
        in_data  = d;
        err_clr  = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic step2(input logic v, input logic [15:0] d,
                         input logic clr);
        in_valid2 = v;
        in_data2  = d;
        err_clr2  = clr;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        err_clr2  = 1'b0;
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        rst2 = 1'b1;
        step(1'b1, 16'h1234, 1'b1);
        rst  = 1'b0;
        rst2 = 1'b0;
        tests++;
        if (locked !== 1'b0) begin
            fails++;
            $display("FAIL reset_locked: got %b want 0", locked);
        end
        tests++;
        if (err_pulse !== 1'b0) begin
            fails++;
            $display("FAIL reset_pulse: got %b want 0", err_pulse);
        end
        tests++;
        if (err_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d want 0", err_count);
        end
        tests++;
        if (locked2 !== 1'b0 || err_count2 !== 4'd0) begin
            fails++;
            $display("FAIL reset_dut4: got %b/%0d want 0/0",
                     locked2, err_count2);
        end
        ecnt = 0;
    endtask

    task automatic test_clean_lock;
        int bad;
        bad = 0;
        gen = 16'hACE1;
        for (int i = 1; i <= 1000; i++) begin
            step(1'b1, gen, 1'b0);
            gen = nxt(gen);
            tests++;
            if (locked !== (i >= 5)) begin
                fails++;
                $display("FAIL clean_lock word %0d: got %b want %b",
                         i, locked, (i >= 5));
            end
            if (err_pulse !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL clean_pulses: got %0d want 0", bad);
        end
        tests++;
        if (err_count !== 16'd0) begin
            fails++;
            $display("FAIL clean_count: got %0d want 0", err_count);
        end
    endtask

    task automatic test_gaps_zero;
        int k;
        rst = 1'b1;
        step(1'b0, 16'h0, 1'b0);
        rst = 1'b0;
        ecnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h0000, 1'b0);
            tests++;
            if (locked !== 1'b0) begin
                fails++;
                $display("FAIL zero_hunt: got %b want 0", locked);
            end
        end
        gen = 16'($urandom_range(1, 16'hFFFF));
        k = 0;
        while (k < 8) begin
            if ($urandom_range(0, 2) == 0) begin
                step(1'b0, 16'($urandom), 1'b0);
            end else begin
                step(1'b1, gen, 1'b0);
                gen = nxt(gen);
                k++;
            end
            tests++;
            if (locked !== (k >= 5) || err_pulse !== 1'b0) begin
                fails++;
                $display("FAIL gap_lock k=%0d: got %b/%b want %b/0",
                         k, locked, err_pulse, (k >= 5));
            end
        end
    endtask

    task automatic test_single_error;
        for (int n = 0; n < 4; n++) begin
            logic [15:0] m;
            m = (n == 0) ? 16'h0008 : rand_mask();
            step(1'b1, gen ^ m, 1'b0);
            gen = nxt(gen);
            ecnt++;
            tests++;
            if (err_pulse !== 1'b1 || locked !== 1'b1 ||
                err_count !== 16'(ecnt)) begin
                fails++;
                $display("FAIL single_err: got %b/%b/%0d want 1/1/%0d",
                         err_pulse, locked, err_count, ecnt);
            end
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 1) == 0)
                    step(1'b0, 16'($urandom), 1'b0);
                step(1'b1, gen, 1'b0);
                gen = nxt(gen);
                tests++;
                if (err_pulse !== 1'b0 || locked !== 1'b1 ||
                    err_count !== 16'(ecnt)) begin
                    fails++;
                    $display("FAIL after_err: got %b/%b/%0d want 0/1/%0d",
                             err_pulse, locked, err_count, ecnt);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int j = 0; j < 2; j++) begin
            step(1'b1, gen ^ rand_mask(), 1'b0);
            gen = nxt(gen);
            ecnt++;
            tests++;
            if (err_pulse !== 1'b1 || locked !== 1'b1) begin
                fails++;
                $display("FAIL b2b_err %0d: got %b/%b want 1/1",
                         j, err_pulse, locked);
            end
        end
        step(1'b1, gen, 1'b0);
        gen = nxt(gen);
        tests++;
        if (err_pulse !== 1'b0 || locked !== 1'b1) begin
            fails++;
            $display("FAIL b2b_match: got %b/%b want 0/1",
                     err_pulse, locked);
        end
        for (int j = 0; j < 2; j++) begin
            step(1'b1, gen ^ rand_mask(), 1'b0);
            gen = nxt(gen);
            ecnt++;
        end
        tests++;
        if (locked !== 1'b1 || err_count !== 16'(ecnt)) begin
            fails++;
            $display("FAIL b2b_miss_reset: got %b/%0d want 1/%0d",
                     locked, err_count, ecnt);
        end
        step(1'b1, gen, 1'b0);
        gen = nxt(gen);
    endtask

    task automatic test_loss_relock;
        for (int j = 1; j <= 3; j++) begin
            step(1'b1, gen ^ rand_mask(), 1'b0);
            gen = nxt(gen);
            ecnt++;
            tests++;
            if (err_pulse !== 1'b1 || locked !== (j < 3) ||
                err_count !== 16'(ecnt)) begin
                fails++;
                $display("FAIL loss %0d: got %b/%b/%0d want 1/%b/%0d",
                         j, err_pulse, locked, err_count, (j < 3), ecnt);
            end
        end
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, gen, 1'b0);
            gen = nxt(gen);
            tests++;
            if (locked !== (i == 5) || err_pulse !== 1'b0 ||
                err_count !== 16'(ecnt)) begin
                fails++;
                $display("FAIL relock %0d: got %b/%b/%0d want %b/0/%0d",
                         i, locked, err_pulse, err_count, (i == 5), ecnt);
            end
        end
    endtask

    task automatic test_err_clr;
        step(1'b0, 16'h0, 1'b1);
        ecnt = 0;
        tests++;
        if (err_count !== 16'd0) begin
            fails++;
            $display("FAIL clr_alone: got %0d want 0", err_count);
        end
        step(1'b1, gen ^ rand_mask(), 1'b0);
        gen = nxt(gen);
        step(1'b1, gen, 1'b0);
        gen = nxt(gen);
        step(1'b1, gen ^ rand_mask(), 1'b1);
        gen = nxt(gen);
        ecnt = 1;
        tests++;
        if (err_count !== 16'd1 || err_pulse !== 1'b1) begin
            fails++;
            $display("FAIL clr_with_err: got %0d/%b want 1/1",
                     err_count, err_pulse);
        end
        step(1'b1, gen, 1'b0);
        gen = nxt(gen);
    endtask

    task automatic test_saturation;
        int exp4;
        gen2 = 16'($urandom_range(1, 16'hFFFF));
        for (int i = 0; i < 5; i++) begin
            step2(1'b1, gen2, 1'b0);
            gen2 = nxt(gen2);
        end
        tests++;
        if (locked2 !== 1'b1) begin
            fails++;
            $display("FAIL sat_lock: got %b want 1", locked2);
        end
        for (int e = 1; e <= 20; e++) begin
            step2(1'b1, gen2 ^ rand_mask(), 1'b0);
            gen2 = nxt(gen2);
            step2(1'b1, gen2, 1'b0);
            gen2 = nxt(gen2);
            exp4 = (e > 15) ? 15 : e;
            tests++;
            if (err_count2 !== 4'(exp4) || locked2 !== 1'b1) begin
                fails++;
                $display("FAIL sat %0d: got %0d/%b want %0d/1",
                         e, err_count2, locked2, exp4);
            end
        end
        step2(1'b0, 16'h0, 1'b1);
        tests++;
        if (err_count2 !== 4'd0) begin
            fails++;
            $display("FAIL sat_clr: got %0d want 0", err_count2);
        end
        step2(1'b1, gen2 ^ rand_mask(), 1'b1);
        gen2 = nxt(gen2);
        tests++;
        if (err_count2 !== 4'd1) begin
            fails++;
            $display("FAIL sat_clr_err: got %0d want 1", err_count2);
        end
    endtask

    task automatic test_reset_locked;
        tests++;
        if (locked !== 1'b1 || err_count === 16'd0) begin
            fails++;
            $display("FAIL pre_rst: got %b/%0d want 1/nonzero",
                     locked, err_count);
        end
        rst = 1'b1;
        step(1'b1, gen ^ 16'h0100, 1'b1);
        rst = 1'b0;
        gen = nxt(gen);
        tests++;
        if (locked !== 1'b0 || err_count !== 16'd0 ||
            err_pulse !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst: got %b/%0d/%b want 0/0/0",
                     locked, err_count, err_pulse);
        end
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, gen, 1'b0);
            gen = nxt(gen);
            tests++;
            if (locked !== (i == 5)) begin
                fails++;
                $display("FAIL rst_relock %0d: got %b want %b",
                         i, locked, (i == 5));
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_clean_lock();
        test_gaps_zero();
        test_single_error();
        test_back_to_back();
        test_loss_relock();
        test_err_clr();
        test_saturation();
        test_reset_locked();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
